// File: rtl/fpdivr4n.sv
// Iterative non-restoring divider: q = floor(a*2^WID / b), r = remainder.
// Retires BPC quotient bits per enabled clock; zero/unit operands bypass iteration.
module fpdivr4n #(
  parameter int WID = 24,
  parameter int BPC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WID-1:0]       a,
  input  logic [WID-1:0]       b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WID-1:0]     q,
  output logic [WID-1:0]       r,
  output logic                 dbz,
  output logic                 busy
);

  localparam int ITERS = 2 * WID / BPC;
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(ITERS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (!((BPC == 1) || (BPC == 2) || (BPC == 4)) || ((2 * WID) % BPC != 0)) begin : g_bad_bpc
    $error("fpdivr4n: BPC must be 1, 2 or 4 and must divide 2*WID");
  end

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*WID-1:0]      q_q, q_d;
  logic [WID-1:0]        r_q, r_d;
  logic                  dbz_q, dbz_d;

  logic [2*WID-1:0]      qs_q, qs_d;
  logic signed [WID:0]   pr_q, pr_d;
  logic [WID-1:0]        bl_q, bl_d;

  logic signed [WID:0]   bx;
  logic signed [WID:0]   sh_c;
  logic signed [WID:0]   rem_c;
  logic [2*WID-1:0]      qsh_c;

  // A negative final remainder is one divisor short of the true remainder.
  function automatic logic [WID-1:0] correct_rem(input logic signed [WID:0] x,
                                                 input logic signed [WID:0] d);
    logic signed [WID:0] y;
    y = x[WID] ? x + d : x;
    return WID'(y);
  endfunction

  // Iteration datapath: BPC chained add/sub steps, earliest bit ends highest.
  always_comb begin
    bx    = $signed({1'b0, bl_q});
    rem_c = pr_q;
    qsh_c = qs_q;
    sh_c  = '0;
    for (int k = 0; k < BPC; k++) begin
      sh_c  = $signed({rem_c[WID-1:0], qsh_c[2*WID-1]});
      rem_c = rem_c[WID] ? sh_c + bx : sh_c - bx;
      qsh_c = {qsh_c[2*WID-2:0], ~rem_c[WID]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    qs_d    = qs_q;
    pr_d    = pr_q;
    bl_d    = bl_q;
    if (ce) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            bl_d = b;
            if (b == '0) begin
              q_d     = '1;
              r_d     = a;
              dbz_d   = 1'b1;
              state_d = S_DONE;
            end else if (a == '0) begin
              q_d     = '0;
              r_d     = '0;
              dbz_d   = 1'b0;
              state_d = S_DONE;
            end else if (b == WID'(1)) begin
              q_d     = {a, {WID{1'b0}}};
              r_d     = '0;
              dbz_d   = 1'b0;
              state_d = S_DONE;
            end else begin
              qs_d    = {a, {WID{1'b0}}};
              pr_d    = '0;
              cnt_d   = CNT_INIT;
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          if (abort) begin
            state_d = S_IDLE;
          end else begin
            qs_d  = qsh_c;
            pr_d  = rem_c;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              q_d     = qsh_c;
              r_d     = correct_rem(rem_c, bx);
              dbz_d   = 1'b0;
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (abort || out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  // Working registers are always overwritten before use, so they carry no reset.
  always_ff @(posedge clk) begin
    qs_q <= qs_d;
    pr_q <= pr_d;
    bl_q <= bl_d;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC);
  assign q         = q_q;
  assign r         = r_q;
  assign dbz       = dbz_q;

endmodule
